// File: rtl/gpu_pkg.sv
// Shared GPU sprite-path constants and types used by the blob, arbiter and mixer blocks.
package gpu_pkg;

    localparam int N_SPRITES     = 4;
    localparam int ram_add_width = 16;
    localparam int DATA_W        = 12;
    localparam int TRANSPARENT   = 0;
    localparam int LAYER_W       = 2;

    typedef enum logic [0:0] {
        SEQ_IDLE  = 1'b0,
        SEQ_ISSUE = 1'b1
    } seq_state_t;

    // A candidate only displaces the current winner when strictly above it, so ties keep the lower index.
    function automatic logic layer_above(input logic [LAYER_W-1:0] cand,
                                         input logic [LAYER_W-1:0] acc);
        return (cand > acc);
    endfunction

endpackage

// File: rtl/layer_resolve.sv
// Compare-and-accumulate stage: folds one returned sprite pixel per cycle into the running winner.
module layer_resolve
    import gpu_pkg::*;
#(
    parameter int DATA_W = gpu_pkg::DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic               init,
    input  logic               cand_valid,
    input  logic [DATA_W-1:0]  cand_colour,
    input  logic [LAYER_W-1:0] cand_layer,
    output logic               acc_valid,
    output logic [DATA_W-1:0]  acc_colour,
    output logic [LAYER_W-1:0] acc_layer
);

    logic               acc_valid_r;
    logic [DATA_W-1:0]  acc_colour_r;
    logic [LAYER_W-1:0] acc_layer_r;
    logic               win_s;

    // Next accumulator value, including the candidate presented this cycle.
    always_comb begin
        acc_valid  = acc_valid_r;
        acc_colour = acc_colour_r;
        acc_layer  = acc_layer_r;
        win_s      = cand_valid && (init || !acc_valid_r || layer_above(cand_layer, acc_layer_r));
        if (!step) begin
            acc_valid  = acc_valid_r;
        end else if (win_s) begin
            acc_valid  = 1'b1;
            acc_colour = cand_colour;
            acc_layer  = cand_layer;
        end else if (init) begin
            acc_valid  = 1'b0;
            acc_colour = {DATA_W{1'b0}};
            acc_layer  = {LAYER_W{1'b0}};
        end else begin
            acc_valid  = acc_valid_r;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_valid_r  <= 1'b0;
            acc_colour_r <= {DATA_W{1'b0}};
            acc_layer_r  <= {LAYER_W{1'b0}};
        end else begin
            acc_valid_r  <= acc_valid;
            acc_colour_r <= acc_colour;
            acc_layer_r  <= acc_layer;
        end
    end

endmodule

// File: rtl/pixel_arbiter.sv
// Sprite pixel arbiter: captures a group of blob requests, reads each from sprite RAM in
// index order and resolves the topmost non-transparent colour at a fixed latency.
module pixel_arbiter
    import gpu_pkg::*;
#(
    parameter int N_SPRITES     = gpu_pkg::N_SPRITES,
    parameter int ram_add_width = gpu_pkg::ram_add_width,
    parameter int DATA_W        = gpu_pkg::DATA_W,
    parameter int TRANSPARENT   = gpu_pkg::TRANSPARENT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_SPRITES-1:0]               req,
    input  logic [N_SPRITES*ram_add_width-1:0] addr_in,
    input  logic [N_SPRITES*LAYER_W-1:0]       layer_in,
    output logic                               ram_en,
    output logic [ram_add_width-1:0]           ram_addr,
    input  logic [DATA_W-1:0]                  ram_data,
    output logic [DATA_W-1:0]                  pixel_out,
    output logic [LAYER_W-1:0]                 pixel_layer,
    output logic                               pixel_valid,
    output logic                               overrun,
    input  logic                               overrun_clr
);

    localparam int                SLOT_W    = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SPRITES - 1);
    localparam logic [DATA_W-1:0] KEY       = DATA_W'(TRANSPARENT);

    seq_state_t                         state_r, state_nxt_s;
    logic [SLOT_W-1:0]                  slot_r, slot_nxt_s;
    logic                               last_s, free_s, capture_s, drop_s;
    logic [N_SPRITES-1:0]               grp_req_r, src_req_s;
    logic [N_SPRITES*ram_add_width-1:0] grp_addr_r, src_addr_s;
    logic [N_SPRITES*LAYER_W-1:0]       grp_layer_r;
    logic                               issue_en_s;
    logic [ram_add_width-1:0]           issue_addr_s;
    logic                               ram_en_r, overrun_r;
    logic [ram_add_width-1:0]           ram_addr_r;
    logic                               rsp_active_r, rsp_first_r, rsp_last_r, rsp_req_r;
    logic [LAYER_W-1:0]                 rsp_layer_r;
    logic                               cand_valid_s, acc_valid_s;
    logic [DATA_W-1:0]                  acc_colour_s;
    logic [LAYER_W-1:0]                 acc_layer_s;
    logic                               pixel_valid_r;
    logic [DATA_W-1:0]                  pixel_out_r;
    logic [LAYER_W-1:0]                 pixel_layer_r;

    assign last_s    = (state_r == SEQ_ISSUE) && (slot_r == LAST_SLOT);
    assign free_s    = (state_r == SEQ_IDLE) || last_s;
    assign capture_s = (req != {N_SPRITES{1'b0}}) && free_s;
    assign drop_s    = (req != {N_SPRITES{1'b0}}) && !free_s;

    // Slot sequencer next state; a group captured in the last slot chains straight into slot 0.
    always_comb begin
        state_nxt_s = state_r;
        slot_nxt_s  = slot_r;
        case (state_r)
            SEQ_IDLE: begin
                state_nxt_s = capture_s ? SEQ_ISSUE : SEQ_IDLE;
                slot_nxt_s  = {SLOT_W{1'b0}};
            end
            SEQ_ISSUE: begin
                if (last_s) begin
                    state_nxt_s = capture_s ? SEQ_ISSUE : SEQ_IDLE;
                    slot_nxt_s  = {SLOT_W{1'b0}};
                end else begin
                    state_nxt_s = SEQ_ISSUE;
                    slot_nxt_s  = slot_r + 1'b1;
                end
            end
            default: begin
                state_nxt_s = SEQ_IDLE;
                slot_nxt_s  = {SLOT_W{1'b0}};
            end
        endcase
    end

    // RAM strobe/address for the slot issued next cycle, taken from the group being captured if any.
    always_comb begin
        src_req_s    = capture_s ? req : grp_req_r;
        src_addr_s   = capture_s ? addr_in : grp_addr_r;
        issue_en_s   = 1'b0;
        issue_addr_s = {ram_add_width{1'b0}};
        if (state_nxt_s == SEQ_ISSUE) begin
            issue_en_s   = src_req_s[slot_nxt_s];
            issue_addr_s = src_addr_s[int'(slot_nxt_s)*ram_add_width +: ram_add_width];
        end else begin
            issue_en_s   = 1'b0;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SEQ_IDLE;
            slot_r  <= {SLOT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            slot_r  <= slot_nxt_s;
        end
    end

    // Group capture, RAM request outputs and sticky overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            grp_req_r   <= {N_SPRITES{1'b0}};
            grp_addr_r  <= {(N_SPRITES*ram_add_width){1'b0}};
            grp_layer_r <= {(N_SPRITES*LAYER_W){1'b0}};
            ram_en_r    <= 1'b0;
            ram_addr_r  <= {ram_add_width{1'b0}};
            overrun_r   <= 1'b0;
        end else begin
            if (capture_s) begin
                grp_req_r   <= req;
                grp_addr_r  <= addr_in;
                grp_layer_r <= layer_in;
            end
            ram_en_r   <= issue_en_s;
            ram_addr_r <= issue_addr_s;
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (overrun_clr) begin
                overrun_r <= 1'b0;
            end
        end
    end

    // Slot bookkeeping delayed one cycle to line up with the RAM return data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_active_r <= 1'b0;
            rsp_first_r  <= 1'b0;
            rsp_last_r   <= 1'b0;
            rsp_req_r    <= 1'b0;
            rsp_layer_r  <= {LAYER_W{1'b0}};
        end else begin
            rsp_active_r <= (state_r == SEQ_ISSUE);
            rsp_first_r  <= (slot_r == {SLOT_W{1'b0}});
            rsp_last_r   <= last_s;
            rsp_req_r    <= ram_en_r;
            rsp_layer_r  <= grp_layer_r[int'(slot_r)*LAYER_W +: LAYER_W];
        end
    end

    assign cand_valid_s = rsp_active_r && rsp_req_r && (ram_data != KEY);

    layer_resolve #(
        .DATA_W (DATA_W)
    ) u_resolve (
        .clk         (clk),
        .rst         (rst),
        .step        (rsp_active_r),
        .init        (rsp_first_r),
        .cand_valid  (cand_valid_s),
        .cand_colour (ram_data),
        .cand_layer  (rsp_layer_r),
        .acc_valid   (acc_valid_s),
        .acc_colour  (acc_colour_s),
        .acc_layer   (acc_layer_s)
    );

    // Result register: presents the final accumulator for one cycle, zero otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_valid_r <= 1'b0;
            pixel_out_r   <= {DATA_W{1'b0}};
            pixel_layer_r <= {LAYER_W{1'b0}};
        end else if (rsp_active_r && rsp_last_r) begin
            pixel_valid_r <= acc_valid_s;
            pixel_out_r   <= acc_colour_s;
            pixel_layer_r <= acc_layer_s;
        end else begin
            pixel_valid_r <= 1'b0;
            pixel_out_r   <= {DATA_W{1'b0}};
            pixel_layer_r <= {LAYER_W{1'b0}};
        end
    end

    assign ram_en      = ram_en_r;
    assign ram_addr    = ram_addr_r;
    assign pixel_valid = pixel_valid_r;
    assign pixel_out   = pixel_out_r;
    assign pixel_layer = pixel_layer_r;
    assign overrun     = overrun_r;

endmodule

// File: tb/tb_pixel_arbiter.sv
// Self-checking bench for pixel_arbiter: directed scenarios then randomized traffic,
// all checked against a group-level reference model of the arbitration rules.
module tb_pixel_arbiter;

    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 12;
    localparam int LAT = N + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*AW-1:0] addr_in;
    logic [N*2-1:0]  layer_in;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data = 12'h000;
    logic [DW-1:0] pixel_out;
    logic [1:0]    pixel_layer;
    logic          pixel_valid;
    logic          overrun;
    logic          overrun_clr;

    logic [DW-1:0] mem [0:65535];

    pixel_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .addr_in     (addr_in),
        .layer_in    (layer_in),
        .ram_en      (ram_en),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .pixel_out   (pixel_out),
        .pixel_layer (pixel_layer),
        .pixel_valid (pixel_valid),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    // Sprite RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) ram_data <= mem[ram_addr];
    end

    typedef struct {
        int            due;
        logic          valid;
        logic [DW-1:0] colour;
        logic [1:0]    layer;
    } exp_t;

    exp_t          pend[$];
    int            cyc = 0;
    int            nchecks = 0;
    int            nerr = 0;
    int            last_t = -100;
    logic          grp_act = 1'b0;
    logic [N-1:0]  grp_req = 4'b0000;
    logic [AW-1:0] grp_addr [N];
    logic          exp_ovr = 1'b0;
    logic          rst_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [N*AW-1:0] pa(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                           input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [N*2-1:0] pl(input logic [1:0] l0, input logic [1:0] l1,
                                          input logic [1:0] l2, input logic [1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Topmost layer among visible requested pixels; the lowest index holding that layer wins.
    function automatic exp_t resolve(input logic [N-1:0] r, input logic [N*AW-1:0] a,
                                     input logic [N*2-1:0] l, input int due);
        exp_t e;
        int   top = -1;
        int   win = -1;
        e.due = due; e.valid = 1'b0; e.colour = 12'h000; e.layer = 2'd0;
        for (int i = 0; i < N; i++)
            if (r[i] && mem[a[i*AW +: AW]] != 12'h000 && int'(l[i*2 +: 2]) > top) top = int'(l[i*2 +: 2]);
        for (int i = N - 1; i >= 0; i--)
            if (r[i] && mem[a[i*AW +: AW]] != 12'h000 && int'(l[i*2 +: 2]) == top) win = i;
        if (win >= 0) begin
            e.valid  = 1'b1;
            e.layer  = 2'(top);
            e.colour = mem[a[win*AW +: AW]];
        end
        return e;
    endfunction

    task automatic check_outputs();
        int   k;
        exp_t e;
        k = cyc - last_t - 1;
        if (grp_act && k >= 0 && k < N) begin
            chk("ram_en", 32'(ram_en), 32'(grp_req[k]));
            chk("ram_addr", 32'(ram_addr), 32'(grp_addr[k]));
        end else begin
            chk("ram_en_idle", 32'(ram_en), 32'd0);
            if (rst_seen) chk("ram_addr_rst", 32'(ram_addr), 32'd0);
        end
        e.due = cyc; e.valid = 1'b0; e.colour = 12'h000; e.layer = 2'd0;
        if (pend.size() > 0 && pend[0].due == cyc) e = pend.pop_front();
        chk("pixel_valid", 32'(pixel_valid), 32'(e.valid));
        chk("pixel_out", 32'(pixel_out), 32'(e.colour));
        chk("pixel_layer", 32'(pixel_layer), 32'(e.layer));
        chk("overrun", 32'(overrun), 32'(exp_ovr));
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N*AW-1:0] a, input logic [N*2-1:0] l,
                        input logic rs, input logic clr);
        logic drop;
        req = r; addr_in = a; layer_in = l; rst = rs; overrun_clr = clr;
        rst_seen = rs;
        if (rs) begin
            pend.delete();
            grp_act = 1'b0;
            last_t  = -100;
            exp_ovr = 1'b0;
        end else begin
            drop = (r != 4'b0000) && (cyc < last_t + N);
            if (r != 4'b0000 && !drop) begin
                last_t  = cyc;
                grp_act = 1'b1;
                grp_req = r;
                for (int i = 0; i < N; i++) grp_addr[i] = a[i*AW +: AW];
                pend.push_back(resolve(r, a, l, cyc + LAT));
            end
            if (drop) exp_ovr = 1'b1;
            else if (clr) exp_ovr = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 64'h0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        logic [N-1:0]    rr;
        logic [N*AW-1:0] ra;
        for (int i = 0; i < 65536; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
        mem[16'h0100] = 12'hF00;
        mem[16'h0200] = 12'h111; mem[16'h0201] = 12'h222;
        mem[16'h0202] = 12'h333; mem[16'h0203] = 12'h444;
        mem[16'h0300] = 12'h0A5; mem[16'h0301] = 12'h000;
        mem[16'h0400] = 12'h000; mem[16'h0401] = 12'h000;
        mem[16'h0402] = 12'h000; mem[16'h0403] = 12'h000;

        step(4'b0000, 64'h0, 8'h00, 1'b1, 1'b0);
        step(4'b0000, 64'h0, 8'h00, 1'b1, 1'b0);
        idle(2);

        // single requester
        step(4'b0001, pa(16'h0100, 16'h0200, 16'h0201, 16'h0202), pl(2'd2, 2'd3, 2'd3, 2'd3), 1'b0, 1'b0);
        idle(8);
        // layer tie goes to lower index
        step(4'b1111, pa(16'h0200, 16'h0201, 16'h0202, 16'h0203), pl(2'd1, 2'd3, 2'd3, 2'd2), 1'b0, 1'b0);
        idle(8);
        // transparent top pixel falls through
        step(4'b0011, pa(16'h0300, 16'h0301, 16'h0200, 16'h0201), pl(2'd0, 2'd3, 2'd3, 2'd3), 1'b0, 1'b0);
        idle(8);
        // back-to-back groups, third dropped
        step(4'b1111, pa(16'h0200, 16'h0201, 16'h0202, 16'h0203), pl(2'd0, 2'd1, 2'd2, 2'd3), 1'b0, 1'b0);
        idle(3);
        step(4'b1111, pa(16'h0100, 16'h0200, 16'h0201, 16'h0202), pl(2'd3, 2'd3, 2'd0, 2'd1), 1'b0, 1'b0);
        step(4'b0001, pa(16'h0300, 16'h0000, 16'h0000, 16'h0000), pl(2'd3, 2'd0, 2'd0, 2'd0), 1'b0, 1'b0);
        idle(8);
        step(4'b0000, 64'h0, 8'h00, 1'b0, 1'b1);
        idle(2);
        // drop and clear in the same cycle keeps overrun set
        step(4'b0010, pa(16'h0000, 16'h0201, 16'h0000, 16'h0000), pl(2'd0, 2'd2, 2'd0, 2'd0), 1'b0, 1'b0);
        step(4'b0100, pa(16'h0000, 16'h0000, 16'h0202, 16'h0000), pl(2'd0, 2'd0, 2'd1, 2'd0), 1'b0, 1'b1);
        idle(8);
        step(4'b0000, 64'h0, 8'h00, 1'b0, 1'b1);
        // reset mid-group, then a fresh group
        step(4'b1111, pa(16'h0200, 16'h0201, 16'h0202, 16'h0203), pl(2'd1, 2'd2, 2'd3, 2'd0), 1'b0, 1'b0);
        idle(2);
        step(4'b0000, 64'h0, 8'h00, 1'b1, 1'b0);
        idle(6);
        step(4'b0101, pa(16'h0100, 16'h0000, 16'h0203, 16'h0000), pl(2'd1, 2'd0, 2'd2, 2'd0), 1'b0, 1'b0);
        idle(8);
        // request coincident with reset is ignored
        step(4'b1111, pa(16'h0200, 16'h0201, 16'h0202, 16'h0203), pl(2'd1, 2'd2, 2'd3, 2'd0), 1'b1, 1'b0);
        idle(8);
        // everything transparent
        step(4'b1111, pa(16'h0400, 16'h0401, 16'h0402, 16'h0403), pl(2'd3, 2'd2, 2'd1, 2'd0), 1'b0, 1'b0);
        idle(8);

        for (int n = 0; n < 600; n++) begin
            rr = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
            for (int i = 0; i < N; i++) ra[i*AW +: AW] = 16'($urandom);
            step(rr, ra, 8'($urandom), ($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0));
        end
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/pixel_arbiter.md
PIXEL_ARBITER -- requirements
Module: pixel_arbiter

Interface
REQ-001 Parameter N_SPRITES, default 4, number of blob requesters; fixes slot count and latency.
REQ-002 Parameter ram_add_width, default 16, sprite RAM address width.
REQ-003 Parameter DATA_W, default 12, pixel colour width.
REQ-004 Parameter TRANSPARENT, default 0, colour key treated as "no pixel".
REQ-005 clk  in  1  system clock, 100 MHz.
REQ-006 rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-007 req  in  N_SPRITES  per-blob one-cycle request pulse.
REQ-008 addr_in  in  N_SPRITES*ram_add_width  per-blob pixel address; slice i belongs to req[i].
REQ-009 layer_in  in  N_SPRITES*2  per-blob layer; higher value is drawn on top.
REQ-010 ram_en  out  1  sprite RAM read strobe.
REQ-011 ram_addr  out  ram_add_width  sprite RAM read address.
REQ-012 ram_data  in  DATA_W  RAM read data, valid the cycle after ram_en.
REQ-013 pixel_out  out  DATA_W  resolved sprite colour.
REQ-014 pixel_layer  out  2  layer of the resolved colour.
REQ-015 pixel_valid  out  1  one-cycle pulse when pixel_out holds a non-transparent sprite pixel.
REQ-016 overrun  out  1  sticky flag set when a request group is dropped.
REQ-017 overrun_clr  in  1  clears overrun.

Function
REQ-018 Any cycle T with req != 0 and a free capture slot SHALL latch the req mask, all addr_in and all layer_in as group G.
REQ-019 Capture slot SHALL be free when the slot sequencer is idle or issuing its last slot (N_SPRITES-1).
REQ-020 Sequencer states: IDLE, ISSUE(slot 0..N_SPRITES-1); IDLE->ISSUE(0) after capture; ISSUE(k)->ISSUE(k+1); ISSUE(last)->ISSUE(0) if a new group was captured that cycle, else IDLE.
REQ-021 In cycle T+1+i the block SHALL drive ram_addr = addr of requester i, with ram_en = 1 only if mask bit i is set; otherwise ram_en = 0.
REQ-022 Return data for slot i (cycle T+2+i) SHALL be resolved in index order: a candidate replaces the accumulator if it is non-transparent and the accumulator is empty or its layer is strictly greater.
REQ-023 Equal layers: lower index wins. Transparent or unrequested slots never change the accumulator.
REQ-024 In cycle T+N_SPRITES+2 (T+6 at default), pixel_out and pixel_layer SHALL hold the result, with pixel_valid = 1 only if the accumulator is non-empty.
REQ-025 When pixel_valid = 0, pixel_out and pixel_layer SHALL be 0.
REQ-026 Latency SHALL be fixed; back-to-back groups every N_SPRITES cycles SHALL give results every N_SPRITES cycles with no gaps.
REQ-027 A request arriving while the capture slot is not free SHALL be dropped whole and SHALL set overrun. The in-flight group SHALL be unaffected.
REQ-028 overrun_clr and a new overrun event in the same cycle: overrun SHALL stay 1.
REQ-029 Layer comparison SHALL be unsigned, 2 bits; addresses SHALL pass through unmodified, with no arithmetic.

Reset
REQ-030 While rst = 1: ram_en, ram_addr, pixel_out, pixel_layer, pixel_valid and overrun SHALL be 0, the sequencer SHALL be IDLE, and the latched group and accumulator SHALL be cleared.
REQ-031 Reset mid-group SHALL discard the group: no pixel_valid until a new group is captured after reset release.
REQ-032 req asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-033 Shared package gpu_pkg SHALL hold ram_add_width, DATA_W, N_SPRITES, TRANSPARENT and LAYER_W = 2 for use by the blob and video mixer blocks.
REQ-034 The compare and accumulate stage SHALL be a sub-module named layer_resolve: candidate colour/layer/valid in, accumulator out, with an init strobe for slot 0.

Verification
REQ-035 Scenario: req = 0001, addr0 = 0x0100, RAM[0x0100] = 0xF00, request at T -> ram_en only at T+1, address 0x0100; at T+6 pixel_valid = 1, pixel_out = 0xF00, pixel_layer = layer0.
REQ-036 Scenario: req = 1111, layers 1,3,3,2, all non-transparent -> result is requester 1's colour, layer 3 (tie resolved to lower index).
REQ-037 Scenario: req = 0011, requester 1 pixel = 0x000 (transparent), layer 3; requester 0 layer 0 = 0x0A5 -> pixel_out = 0x0A5, pixel_layer = 0.
REQ-038 Scenario: groups at T and T+4, then a third req at T+5 -> results at T+6 and T+10; group 3 dropped; overrun = 1 until an overrun_clr pulse.
REQ-039 Scenario: rst pulsed at T+3 of a group -> ram_en = 0 and no pixel_valid at T+6; next group at T+10 resolves normally.
REQ-040 Scenario: all requested pixels transparent -> pixel_valid = 0 and pixel_out = 0 at T+6.
